rand_mem_check: RTL
===================

# rand_mem_check

Read-back verifier for the 1-bit random-fill framebuffer. On a start pulse it sweeps every memory address and reads each bit through a synchronous read port. It regenerates the same 32-bit LFSR stream the fill writer uses and compares the two, reporting a pass/fail flag, a mismatch count and the first failing address. It sits on the framebuffer's read side, alongside the fill writer, for power-on self-test and for bench checks of the image path.

## Interface

Parameters:
- AW, 16, memory address width; the sweep covers 2^AW addresses.
- RD_LAT, 1, read latency of the memory in clocks (1 or 2) from o_addr/o_rd_en to valid i_dat.
- SEED, 32'h1, LFSR state corresponding to address 0.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  single-cycle start request; honoured only in IDLE.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse when the sweep result is final.
- o_pass  out  1  1 when the last sweep had zero mismatches; held until the next start.
- o_err_cnt  out  AW+1  mismatch count of the current or last sweep.
- o_first_err  out  AW  address of the first mismatch; valid when o_err_cnt != 0.
- o_addr  out  AW  memory read address.
- o_rd_en  out  1  read strobe.
- i_dat  in  1  memory read data.

## Operation

- Reset values: state IDLE, o_busy 0, o_done 0, o_pass 0, o_err_cnt 0, o_first_err 0, o_addr 0, o_rd_en 0, LFSR = SEED.
- LFSR step: l_next = {l[30:0], l[31]^l[21]^l[1]^l[0]}. The expected bit for address k is l[31] after k steps from SEED.
- The FSM has four states:
  - IDLE: on i_start, clear o_err_cnt, o_first_err and o_pass, load LFSR with SEED, then go to SCAN.
  - SCAN: assert o_rd_en and issue o_addr = 0, 1, … 2^AW-1, one per clock. Step the LFSR each cycle. The expected bit enters an RD_LAT-deep delay line with a valid tag. After the last address, go to DRAIN.
  - DRAIN: o_rd_en is 0. Wait until the delay line is empty (RD_LAT cycles), then go to DONE.
  - DONE: pulse o_done for one cycle, set o_pass = (o_err_cnt == 0), then go to IDLE.
- Compare: when the delayed valid tag is 1 and i_dat != the delayed expected bit:
  - increment o_err_cnt; width AW+1, so it cannot overflow;
  - if this is the first mismatch of the sweep, capture the delayed address into o_first_err.
- The address counter must not wrap into a second pass. Termination is decided on address 2^AW-1, not on overflow.
- i_start while o_busy is ignored; there is no restart.
- Reset mid-sweep returns everything to reset values immediately. No o_done is issued for an aborted sweep.

## Timing

- Start accepted at edge t. Then:
  - address k is driven during cycle t+1+k;
  - its data is compared at edge t+1+k+RD_LAT;
  - the last compare is at t+2^AW+RD_LAT;
  - o_done is high in cycle t+2^AW+RD_LAT+1, and o_busy falls in that same cycle.
- o_pass and o_err_cnt are final and stable when o_done is high.
- Back-to-back: i_start asserted in the o_done cycle is ignored. The earliest accepted start is in the following IDLE cycle.
- Outputs are registered; there is no combinational path from i_dat to any output.

## Structure

- Shared package (rand_mem_pkg):
  - LFSR width 32, tap positions 31/21/1/0, the lfsr_next function, the default seed constant;
  - also used by the fill writer, so both ends cannot diverge.
- One sub-module, lfsr32: load/enable inputs, 32-bit state, o_bit = state[31].
- The delay line (expected bit, valid, address) is a generic RD_LAT-stage shift register inside rand_mem_check.

## Test plan

- Seed 1, AW=16, RD_LAT=1, memory preloaded with the correct stream. Addresses 0..30 hold 0 and address 31 holds 1. Start → o_done at exactly cycle t+65538, o_pass=1, o_err_cnt=0.
- Same image with address 31 forced to 0 and address 1000 inverted → o_err_cnt=2, o_first_err=31, o_pass=0.
- All-zero memory, AW=8 → o_err_cnt equals the count of ones in the first 256 stream bits (from the reference model), and o_first_err=31.
- RD_LAT=2 with a correct image → o_pass=1, and o_done arrives exactly one cycle later than with RD_LAT=1.
- i_start pulsed mid-sweep → ignored, with no timing change. i_rst asserted at address 500 → all outputs at reset values in the same cycle. A new start then completes normally.
- Fill writer and checker connected through a dual-port RAM. Halt the writer after one pass (seed 1), then start the checker → o_pass=1.

Source files
------------

// File: rtl/rand_mem_pkg.sv
// Shared definitions for the random-fill framebuffer: LFSR polynomial, seed
// and the checker FSM encoding. The fill writer imports the same package.
package rand_mem_pkg;

  localparam int          LFSR_W       = 32;
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;  // bits 31, 21, 1, 0
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rand_mem_check_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous load and step enable; o_bit is the
// bit that the stream presents for the current step.
module lfsr32
  import rand_mem_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [31:0] i_seed,
  output logic        o_bit
);

  logic [31:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_bit = r_state[31];

endmodule

// File: rtl/rand_mem_check.sv
// Read-back verifier: sweeps every address once, compares each read bit with
// the regenerated LFSR stream and reports pass, mismatch count and first error.
module rand_mem_check
  import rand_mem_pkg::*;
#(
  parameter int          AW     = 16,
  parameter int          RD_LAT = 1,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW:0]   o_err_cnt,
  output logic [AW-1:0] o_first_err,
  output logic [AW-1:0] o_addr,
  output logic          o_rd_en,
  input  logic          i_dat
);

  localparam int          DW         = $clog2(RD_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

  chk_state_t          r_state;
  logic [DW-1:0]       r_drain_cnt;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [RD_LAT-1:0]   r_pipe_exp;
  logic [AW-1:0]       r_pipe_addr [RD_LAT];

  logic                w_start;
  logic                w_exp_bit;
  logic                w_last_addr;
  logic                w_miss;
  logic [AW:0]         w_err_next;

  assign w_start     = (r_state == ST_IDLE) && i_start;
  assign w_last_addr = (o_addr == {AW{1'b1}});
  assign w_miss      = r_pipe_vld[RD_LAT-1] && (i_dat != r_pipe_exp[RD_LAT-1]);
  assign w_err_next  = o_err_cnt + {{AW{1'b0}}, w_miss};

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_start),
    .i_en   (r_state == ST_SCAN),
    .i_seed (SEED),
    .o_bit  (w_exp_bit)
  );

  // Expected bit, valid tag and address travel alongside the memory read latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe_vld <= {RD_LAT{1'b0}};
      r_pipe_exp <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) r_pipe_addr[i] <= {AW{1'b0}};
    end else begin
      r_pipe_vld[0]  <= o_rd_en;
      r_pipe_exp[0]  <= w_exp_bit;
      r_pipe_addr[0] <= o_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_exp[i]  <= r_pipe_exp[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  // Sweep FSM; o_pass uses w_err_next so the final compare lands in the same edge as o_done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= {DW{1'b0}};
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_cnt   <= {(AW+1){1'b0}};
      o_first_err <= {AW{1'b0}};
      o_addr      <= {AW{1'b0}};
      o_rd_en     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (w_miss) begin
        o_err_cnt <= w_err_next;
        if (o_err_cnt == {(AW+1){1'b0}}) o_first_err <= r_pipe_addr[RD_LAT-1];
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            o_err_cnt   <= {(AW+1){1'b0}};
            o_first_err <= {AW{1'b0}};
            o_pass      <= 1'b0;
            o_addr      <= {AW{1'b0}};
            o_rd_en     <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_last_addr) begin
            o_rd_en     <= 1'b0;
            r_drain_cnt <= {DW{1'b0}};
            r_state     <= ST_DRAIN;
          end else begin
            o_addr <= o_addr + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            o_pass  <= (w_err_next == {(AW+1){1'b0}});
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
